// File: rtl/game_pkg.sv
// Shared types and widths for the hit detection path of the health bar.
package game_pkg;

  typedef enum logic [1:0] {READY, HIT, COOLDOWN, KO} hit_state_t;

  localparam int COORD_W = 10;
  localparam int SUM_W   = 11;

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap test; edge-touching boxes do not overlap.
module box_overlap
  import game_pkg::*;
#(
  parameter int AW = 32,
  parameter int AH = 48,
  parameter int BW = 8,
  parameter int BH = 8
) (
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               overlap
);

  logic [SUM_W-1:0] ax_e, ay_e, bx_e, by_e;
  logic [SUM_W-1:0] a_right, a_bottom, b_right, b_bottom;

  // One extra bit keeps right/bottom edges near the screen limit from wrapping.
  assign ax_e = {1'b0, ax};
  assign ay_e = {1'b0, ay};
  assign bx_e = {1'b0, bx};
  assign by_e = {1'b0, by};

  assign a_right  = ax_e + SUM_W'(AW);
  assign a_bottom = ay_e + SUM_W'(AH);
  assign b_right  = bx_e + SUM_W'(BW);
  assign b_bottom = by_e + SUM_W'(BH);

  assign overlap = (ax_e < b_right) && (bx_e < a_right) &&
                   (ay_e < b_bottom) && (by_e < a_bottom);

endmodule

// File: rtl/hit_detector.sv
// Per-frame player hit detection with hit pulse, invulnerability frames and KO latch.
//   state    | meaning
//   READY    | vulnerable, waiting for an overlapping frame tick
//   HIT      | hit pulse high for HIT_CYCLES clocks
//   COOLDOWN | invulnerable, counting IFRAMES frame ticks
//   KO       | health reached zero, terminal until reset
module hit_detector
  import game_pkg::*;
#(
  parameter int PW         = 32,
  parameter int PH         = 48,
  parameter int MW         = 24,
  parameter int MH         = 16,
  parameter int PRW        = 8,
  parameter int PRH        = 8,
  parameter int HIT_CYCLES = 4,
  parameter int IFRAMES    = 60
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0] melee_x,
  input  logic [COORD_W-1:0] melee_y,
  input  logic               melee_active,
  input  logic [COORD_W-1:0] proj_x,
  input  logic [COORD_W-1:0] proj_y,
  input  logic               proj_active,
  input  logic [7:0]         health,
  output logic               hit,
  output logic [1:0]         hit_src,
  output logic               proj_consume,
  output logic               invuln,
  output logic               ko,
  output logic [7:0]         hit_count
);

  hit_state_t state, state_nxt;
  logic       frame_clk_q;
  logic       frame_tick;
  logic       m_box, p_box;
  logic       m_ov, p_ov;
  logic       hit_start;
  logic [3:0] hit_cnt;
  logic [7:0] frame_cnt;

  box_overlap #(.AW(PW), .AH(PH), .BW(MW), .BH(MH)) u_melee_ov (
    .ax      (player_x),
    .ay      (player_y),
    .bx      (melee_x),
    .by      (melee_y),
    .overlap (m_box)
  );

  box_overlap #(.AW(PW), .AH(PH), .BW(PRW), .BH(PRH)) u_proj_ov (
    .ax      (player_x),
    .ay      (player_y),
    .bx      (proj_x),
    .by      (proj_y),
    .overlap (p_box)
  );

  assign m_ov       = melee_active & m_box;
  assign p_ov       = proj_active & p_box;
  assign frame_tick = frame_clk & ~frame_clk_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= READY;
    end else begin
      state <= state_nxt;
    end
  end

  // Zero health wins over everything, including a hit starting this cycle.
  always_comb begin
    state_nxt = state;
    hit_start = 1'b0;
    if (health == 8'd0) begin
      state_nxt = KO;
    end else begin
      case (state)
        READY: begin
          if (frame_tick && (m_ov || p_ov)) begin
            state_nxt = HIT;
            hit_start = 1'b1;
          end
        end
        HIT: begin
          if (hit_cnt == 4'd1) state_nxt = COOLDOWN;
        end
        COOLDOWN: begin
          if (frame_tick && frame_cnt == 8'd1) state_nxt = READY;
        end
        KO:      state_nxt = KO;
        default: state_nxt = READY;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_q  <= 1'b0;
      hit_cnt      <= 4'd0;
      frame_cnt    <= 8'd0;
      hit_src      <= 2'b00;
      hit_count    <= 8'd0;
      proj_consume <= 1'b0;
    end else begin
      frame_clk_q  <= frame_clk;
      proj_consume <= hit_start & p_ov;

      if (hit_start) begin
        hit_cnt <= 4'(HIT_CYCLES);
      end else if (state == HIT && hit_cnt != 4'd0) begin
        hit_cnt <= hit_cnt - 4'd1;
      end

      // Frame ticks seen during HIT do not count toward the cooldown.
      if (state == HIT && state_nxt == COOLDOWN) begin
        frame_cnt <= 8'(IFRAMES);
      end else if (state == COOLDOWN && frame_tick && frame_cnt != 8'd0) begin
        frame_cnt <= frame_cnt - 8'd1;
      end

      if (hit_start) begin
        hit_src <= {m_ov, p_ov};
        if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
      end
    end
  end

  assign hit    = (state == HIT);
  assign invuln = (state == COOLDOWN);
  assign ko     = (state == KO);

endmodule

// File: tb/tb_hit_detector.sv
// Directed bench for hit_detector: single-tick vector table plus cooldown, KO and reset sequences.
module tb_hit_detector;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [9:0] player_x = '0, player_y = '0;
  logic [9:0] melee_x = '0, melee_y = '0;
  logic       melee_active = 1'b0;
  logic [9:0] proj_x = '0, proj_y = '0;
  logic       proj_active = 1'b0;
  logic [7:0] health = 8'd100;
  logic       hit;
  logic [1:0] hit_src;
  logic       proj_consume;
  logic       invuln;
  logic       ko;
  logic [7:0] hit_count;

  int checks = 0;
  int failures = 0;

  hit_detector dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .player_x     (player_x),
    .player_y     (player_y),
    .melee_x      (melee_x),
    .melee_y      (melee_y),
    .melee_active (melee_active),
    .proj_x       (proj_x),
    .proj_y       (proj_y),
    .proj_active  (proj_active),
    .health       (health),
    .hit          (hit),
    .hit_src      (hit_src),
    .proj_consume (proj_consume),
    .invuln       (invuln),
    .ko           (ko),
    .hit_count    (hit_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0] px, py;
    logic [9:0] mx, my;
    logic       mact;
    logic [9:0] rx, ry;
    logic       ract;
    logic       exp_hit;
    logic [1:0] exp_src;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    frame_clk = 1'b0;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  // Raises frame_clk for two cycles (one rising edge) and samples n cycles.
  task automatic tick_observe(input int n, output int hcyc, output int ccyc,
                              output int hfirst, output int hlast, output int ifirst);
    hcyc = 0; ccyc = 0; hfirst = -1; hlast = -1; ifirst = -1;
    frame_clk = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      if (i == 1) frame_clk = 1'b0;
      if (hit) begin
        hcyc++;
        if (hfirst < 0) hfirst = i;
        hlast = i;
      end
      if (proj_consume) ccyc++;
      if (invuln && ifirst < 0) ifirst = i;
    end
    frame_clk = 1'b0;
  endtask

  task automatic set_boxes(input vec_t v);
    player_x = v.px; player_y = v.py;
    melee_x = v.mx;  melee_y = v.my;  melee_active = v.mact;
    proj_x = v.rx;   proj_y = v.ry;   proj_active = v.ract;
  endtask

  int hc, cc, hf, hl, inf;
  int nhits, tick1, tick2;
  logic prev_hit;

  initial begin
    // player, melee, mact, proj, pact, exp_hit, exp_src
    vecs[0]  = '{10'd100, 10'd100, 10'd500, 10'd500, 1'b0, 10'd120, 10'd130, 1'b1, 1'b1, 2'b01};
    vecs[1]  = '{10'd100, 10'd100, 10'd500, 10'd500, 1'b0, 10'd132, 10'd100, 1'b1, 1'b0, 2'b00};
    vecs[2]  = '{10'd100, 10'd100, 10'd500, 10'd500, 1'b0, 10'd131, 10'd100, 1'b1, 1'b1, 2'b01};
    vecs[3]  = '{10'd100, 10'd100, 10'd500, 10'd500, 1'b0, 10'd100, 10'd148, 1'b1, 1'b0, 2'b00};
    vecs[4]  = '{10'd100, 10'd100, 10'd500, 10'd500, 1'b0, 10'd100, 10'd147, 1'b1, 1'b1, 2'b01};
    vecs[5]  = '{10'd100, 10'd100, 10'd500, 10'd500, 1'b0, 10'd92,  10'd100, 1'b1, 1'b0, 2'b00};
    vecs[6]  = '{10'd100, 10'd100, 10'd500, 10'd500, 1'b0, 10'd93,  10'd100, 1'b1, 1'b1, 2'b01};
    vecs[7]  = '{10'd100, 10'd100, 10'd80,  10'd90,  1'b1, 10'd500, 10'd500, 1'b1, 1'b1, 2'b10};
    vecs[8]  = '{10'd100, 10'd100, 10'd76,  10'd100, 1'b1, 10'd500, 10'd500, 1'b1, 1'b0, 2'b00};
    vecs[9]  = '{10'd100, 10'd100, 10'd80,  10'd90,  1'b0, 10'd120, 10'd130, 1'b0, 1'b0, 2'b00};
    vecs[10] = '{10'd100, 10'd100, 10'd80,  10'd90,  1'b1, 10'd120, 10'd130, 1'b1, 1'b1, 2'b11};
    vecs[11] = '{10'd0,   10'd0,   10'd500, 10'd500, 1'b0, 10'd0,   10'd0,   1'b1, 1'b1, 2'b01};
    vecs[12] = '{10'd1000, 10'd0,  10'd500, 10'd500, 1'b0, 10'd1020, 10'd0,  1'b1, 1'b1, 2'b01};

    // Reset state
    #1;
    chk("rst_hit", hit, 0);
    chk("rst_src", hit_src, 0);
    chk("rst_consume", proj_consume, 0);
    chk("rst_invuln", invuln, 0);
    chk("rst_ko", ko, 0);
    chk("rst_count", hit_count, 0);

    // Single-tick vectors, each from a fresh reset
    for (int i = 0; i < 13; i++) begin
      health = 8'd100;
      set_boxes(vecs[i]);
      do_reset();
      tick_observe(12, hc, cc, hf, hl, inf);
      chk($sformatf("v%0d_hit_cycles", i), hc, vecs[i].exp_hit ? 4 : 0);
      chk($sformatf("v%0d_consume", i), cc, (vecs[i].exp_hit && vecs[i].exp_src[0]) ? 1 : 0);
      chk($sformatf("v%0d_src", i), hit_src, vecs[i].exp_hit ? vecs[i].exp_src : 2'b00);
      chk($sformatf("v%0d_count", i), hit_count, vecs[i].exp_hit ? 1 : 0);
      if (vecs[i].exp_hit) begin
        chk($sformatf("v%0d_hit_first", i), hf, 0);
        chk($sformatf("v%0d_invuln_after", i), inf, hl + 1);
      end
    end

    // Continuous overlap over 70 ticks: second hit only on tick 62
    set_boxes(vecs[0]);
    health = 8'd100;
    do_reset();
    nhits = 0; tick1 = -1; tick2 = -1; prev_hit = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      frame_clk = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(posedge Clk);
        #1;
        frame_clk = 1'b0;
        if (hit && !prev_hit) begin
          nhits++;
          if (nhits == 1) tick1 = k;
          if (nhits == 2) tick2 = k;
        end
        prev_hit = hit;
      end
    end
    chk("cd_hits", nhits, 2);
    chk("cd_tick1", tick1, 1);
    chk("cd_tick2", tick2, 62);
    chk("cd_count", hit_count, 2);

    // KO from COOLDOWN, then overlaps ignored
    set_boxes(vecs[0]);
    do_reset();
    tick_observe(8, hc, cc, hf, hl, inf);
    chk("ko_pre_invuln", invuln, 1);
    health = 8'd0;
    @(posedge Clk);
    #1;
    chk("ko_cd_ko", ko, 1);
    chk("ko_cd_invuln", invuln, 0);
    chk("ko_cd_hit", hit, 0);
    health = 8'd100;
    tick_observe(8, hc, cc, hf, hl, inf);
    chk("ko_ignored_hit", hc, 0);
    chk("ko_ignored_consume", cc, 0);
    chk("ko_ignored_count", hit_count, 1);
    chk("ko_still", ko, 1);

    // KO from HIT
    do_reset();
    chk("ko_cleared", ko, 0);
    frame_clk = 1'b1;
    @(posedge Clk);
    #1;
    frame_clk = 1'b0;
    chk("ko_hit_pre", hit, 1);
    health = 8'd0;
    @(posedge Clk);
    #1;
    chk("ko_hit_hit", hit, 0);
    chk("ko_hit_ko", ko, 1);
    chk("ko_hit_consume", proj_consume, 0);
    health = 8'd100;

    // Async reset mid-HIT
    do_reset();
    frame_clk = 1'b1;
    @(posedge Clk);
    #1;
    frame_clk = 1'b0;
    @(posedge Clk);
    #1;
    chk("mid_pre_hit", hit, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid_hit", hit, 0);
    chk("mid_count", hit_count, 0);
    chk("mid_src", hit_src, 0);
    chk("mid_invuln", invuln, 0);
    chk("mid_ko", ko, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    tick_observe(12, hc, cc, hf, hl, inf);
    chk("mid_rehit_cycles", hc, 4);
    chk("mid_rehit_count", hit_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
